// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - MDIO management-frame responder with a 32 x 16 register file
//
// Purpose: decodes station-driven MDIO frames sampled on eth_mdc rising edges,
// answers reads addressed to PHY_ADDR by driving the line through mdio_o/mdio_oe,
// and commits writes into an internal register file (regs 2/3 are read-only IDs,
// reg 0 bit 15 triggers a soft reset of the whole file).
//
// Ports:
//   clk       in   system clock, at least 8x eth_mdc
//   rst_n     in   synchronous active-low reset
//   eth_mdc   in   management clock from the station (asynchronous)
//   mdio_i    in   sampled eth_mdio line (asynchronous)
//   mdio_o    out  value driven onto eth_mdio
//   mdio_oe   out  tristate enable for eth_mdio, 1 = drive mdio_o
//   wr_valid  out  one-clk pulse when a register write commits
//   wr_addr   out  register address of the committed write
//   wr_data   out  data of the committed write
//   rd_done   out  one-clk pulse when a read frame releases the line after bit 0
//   busy      out  high from a valid ST bit through frame end
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] ID1      = 16'h0022,
  parameter logic [15:0] ID2      = 16'h1620
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eth_mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_done,
  output logic        busy
);

  localparam int CW = $clog2(PRE_LEN + 1);
  localparam logic [CW-1:0] PRE_FULL = CW'(PRE_LEN);

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_RDAT, S_WDAT
  } state_t;

  // Synchronizers; reset high so releasing reset with MDC high is not an edge.
  logic mdc_s1_q, mdc_s2_q, mdc_d1_q;
  logic mdio_s1_q, mdio_s2_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [14:0]   sh_q, sh_d;
  logic          is_rd_q, is_rd_d;
  logic          match_q, match_d;
  logic [4:0]    regad_q, regad_d;
  logic [15:0]   rd_sh_q, rd_sh_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          busy_q, busy_d;
  logic          wr_valid_q, wr_valid_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          rd_done_q, rd_done_d;
  logic          soft_rst_q, soft_rst_d;

  logic [15:0]   regs_q [32];
  logic          rf_we;
  logic [15:0]   rf_wd;

  logic          mdc_edge;
  logic          mdio_s;
  logic [15:0]   sh_in;

  assign mdc_edge = mdc_s2_q & ~mdc_d1_q;
  assign mdio_s   = mdio_s2_q;
  assign sh_in    = {sh_q, mdio_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdc_s1_q  <= 1'b1;
      mdc_s2_q  <= 1'b1;
      mdc_d1_q  <= 1'b1;
      mdio_s1_q <= 1'b1;
      mdio_s2_q <= 1'b1;
    end else begin
      mdc_s1_q  <= eth_mdc;
      mdc_s2_q  <= mdc_s1_q;
      mdc_d1_q  <= mdc_s2_q;
      mdio_s1_q <= mdio_i;
      mdio_s2_q <= mdio_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    is_rd_d    = is_rd_q;
    match_d    = match_q;
    regad_d    = regad_q;
    rd_sh_d    = rd_sh_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    soft_rst_d = 1'b0;
    rf_we      = 1'b0;
    rf_wd      = (regad_q == 5'd0) ? {1'b0, sh_in[14:0]} : sh_in;

    if (mdc_edge) begin
      case (state_q)
        S_PRE: begin
          if (mdio_s) begin
            if (cnt_q != PRE_FULL) cnt_d = cnt_q + CW'(1);
          end else if (cnt_q == PRE_FULL) begin
            state_d = S_ST;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        S_ST: begin
          if (mdio_s) begin
            state_d   = S_OP;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            state_d = S_PRE;
          end
        end
        S_OP: begin
          sh_d      = sh_in[14:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = '0;
            case (sh_in[1:0])
              2'b10: begin is_rd_d = 1'b1; state_d = S_PHY; end
              2'b01: begin is_rd_d = 1'b0; state_d = S_PHY; end
              default: begin state_d = S_PRE; busy_d = 1'b0; end
            endcase
          end
        end
        S_PHY: begin
          sh_d      = sh_in[14:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            match_d   = (sh_in[4:0] == PHY_ADDR);
            state_d   = S_REG;
            bit_cnt_d = '0;
          end
        end
        S_REG: begin
          sh_d      = sh_in[14:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            regad_d   = sh_in[4:0];
            // Latch the read value now; the line stays released for TA bit 1.
            if (is_rd_q && match_q) rd_sh_d = regs_q[sh_in[4:0]];
            state_d   = S_TA;
            bit_cnt_d = '0;
          end
        end
        S_TA: begin
          if (is_rd_q) begin
            if (match_q) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end
            state_d   = S_RDAT;
            bit_cnt_d = '0;
          end else if (bit_cnt_q == 5'd0) begin
            if (mdio_s) begin
              bit_cnt_d = 5'd1;
            end else begin
              state_d = S_PRE;
              busy_d  = 1'b0;
            end
          end else if (!mdio_s) begin
            state_d   = S_WDAT;
            bit_cnt_d = '0;
          end else begin
            state_d = S_PRE;
            busy_d  = 1'b0;
          end
        end
        S_RDAT: begin
          // Counts 0..15 present data; count 16 is the release edge.
          if (bit_cnt_q == 5'd16) begin
            if (match_q) begin
              mdio_oe_d = 1'b0;
              mdio_o_d  = 1'b1;
              rd_done_d = 1'b1;
            end
            state_d = S_PRE;
            busy_d  = 1'b0;
          end else begin
            if (match_q) begin
              mdio_o_d = rd_sh_q[15];
              rd_sh_d  = {rd_sh_q[14:0], 1'b0};
            end
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_WDAT: begin
          sh_d      = sh_in[14:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            state_d = S_PRE;
            busy_d  = 1'b0;
            if (match_q && regad_q != 5'd2 && regad_q != 5'd3) begin
              rf_we      = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = regad_q;
              wr_data_d  = sh_in;
              soft_rst_d = (regad_q == 5'd0) && sh_in[15];
            end
          end
        end
        default: state_d = S_PRE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_PRE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      is_rd_q    <= 1'b0;
      match_q    <= 1'b0;
      regad_q    <= '0;
      rd_sh_q    <= '0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_done_q  <= 1'b0;
      soft_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      is_rd_q    <= is_rd_d;
      match_q    <= match_d;
      regad_q    <= regad_d;
      rd_sh_q    <= rd_sh_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_done_q  <= rd_done_d;
      soft_rst_q <= soft_rst_d;
    end
  end

  // Soft reset lands one clk after the reg-0 write pulse and restores every entry.
  always_ff @(posedge clk) begin
    if (!rst_n || soft_rst_q) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 2) ? ID1 : (i == 3) ? ID2 : 16'h0000;
      end
    end else if (rf_we) begin
      regs_q[regad_q] <= rf_wd;
    end
  end

  assign mdio_o   = mdio_o_q;
  assign mdio_oe  = mdio_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_done  = rd_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - randomized self-checking bench for mdio_responder
module tb_mdio_responder;

  localparam int         H      = 6;
  localparam logic [4:0] MY_PHY = 5'd1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        eth_mdc = 1'b0;
  logic        mdio_i  = 1'b1;
  logic        mdio_o;
  logic        mdio_oe;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_done;
  logic        busy;

  mdio_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .eth_mdc  (eth_mdc),
    .mdio_i   (mdio_i),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_done  (rd_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          busy_cyc = 0;
  int          oe_cyc   = 0;
  logic [4:0]  last_wa  = '0;
  logic [15:0] last_wd  = '0;

  logic [15:0] ref_regs [32];

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_done) rd_cnt++;
    if (busy) busy_cyc++;
    if (mdio_oe) oe_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = 16'h0000;
    ref_regs[2] = 16'h0022;
    ref_regs[3] = 16'h1620;
  endtask

  task automatic bit_low(input logic b);
    mdio_i = b;
    repeat (H) @(negedge clk);
  endtask

  task automatic bit_high();
    eth_mdc = 1'b1;
    repeat (H) @(negedge clk);
    eth_mdc = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic oe_s);
    bit_low(b);
    oe_s = mdio_oe;
    bit_high();
  endtask

  // Leading 0 clears any ones left over in the preamble counter from earlier traffic.
  task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, output logic any_oe);
    logic        oe_s;
    logic [13:0] hdr;
    any_oe = 1'b0;
    send_bit(1'b0, oe_s);
    any_oe |= oe_s;
    for (int i = 0; i < pre; i++) begin
      send_bit(1'b1, oe_s);
      any_oe |= oe_s;
    end
    hdr = {2'b01, op, phy, ra};
    for (int i = 13; i >= 0; i--) begin
      send_bit(hdr[i], oe_s);
      any_oe |= oe_s;
    end
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] data,
                          input logic [1:0] ta, input int pre, output logic any_oe);
    logic        oe_s;
    logic [17:0] tail;
    send_header(pre, 2'b01, phy, ra, any_oe);
    tail = {ta, data};
    for (int i = 17; i >= 0; i--) begin
      send_bit(tail[i], oe_s);
      any_oe |= oe_s;
    end
    repeat (H) @(negedge clk);
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] ra, input int pre,
                         input int abort_at, output logic [15:0] data, output logic ta1_oe,
                         output logic ta2_oe, output logic ta2_o, output int data_oe,
                         output logic hdr_oe, output logic post_oe);
    logic oe_s, o_s, aborted;
    data = '0; ta1_oe = 1'b0; ta2_oe = 1'b0; ta2_o = 1'b0; data_oe = 0; post_oe = 1'b0;
    aborted = 1'b0;
    send_header(pre, 2'b10, phy, ra, hdr_oe);
    for (int k = 1; k <= 18; k++) begin
      bit_low(1'b1);
      oe_s = mdio_oe;
      o_s  = mdio_o;
      if (k == 1) begin
        ta1_oe = oe_s;
      end else if (k == 2) begin
        ta2_oe = oe_s;
        ta2_o  = o_s;
      end else begin
        data[18-k] = o_s;
        if (oe_s) data_oe++;
      end
      if (k == abort_at) begin
        check_eq("abort_oe_before", 32'(oe_s), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_oe_after", 32'(mdio_oe), 32'd0);
        check_eq("abort_busy_after", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        aborted = 1'b1;
        break;
      end
      bit_high();
    end
    if (!aborted) begin
      repeat (H) @(negedge clk);
      post_oe = mdio_oe;
    end
  endtask

  task automatic run_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] data,
                           input logic [1:0] ta, input int pre);
    int   w0, b0, o0;
    logic any_oe, commit;
    w0 = wr_cnt; b0 = busy_cyc; o0 = oe_cyc;
    do_write(phy, ra, data, ta, pre, any_oe);
    commit = (pre >= 32) && (phy == MY_PHY) && (ta == 2'b10) && (ra != 5'd2) && (ra != 5'd3);
    check_eq("wr_pulses", 32'(wr_cnt - w0), 32'(commit));
    if (commit) begin
      check_eq("wr_addr", 32'(last_wa), 32'(ra));
      check_eq("wr_data", 32'(last_wd), 32'(data));
      if (ra == 5'd0 && data[15]) ref_reset();
      else ref_regs[ra] = data;
    end
    check_eq("wr_never_drives", 32'(oe_cyc - o0), 32'd0);
    check_eq("wr_busy_seen", 32'(busy_cyc - b0 > 0), 32'(pre >= 32));
    check_eq("wr_busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_read(input logic [4:0] phy, input logic [4:0] ra, input int pre);
    int          r0, b0, o0, doe;
    logic [15:0] data;
    logic        ta1, ta2, ta2o, hoe, poe, served;
    r0 = rd_cnt; b0 = busy_cyc; o0 = oe_cyc;
    do_read(phy, ra, pre, 0, data, ta1, ta2, ta2o, doe, hoe, poe);
    served = (pre >= 32) && (phy == MY_PHY);
    check_eq("rd_hdr_oe", 32'(hoe), 32'd0);
    if (served) begin
      check_eq("rd_ta1_oe", 32'(ta1), 32'd0);
      check_eq("rd_ta2_oe", 32'(ta2), 32'd1);
      check_eq("rd_ta2_o", 32'(ta2o), 32'd0);
      check_eq("rd_data", 32'(data), 32'(ref_regs[ra]));
      check_eq("rd_data_oe", 32'(doe), 32'd16);
      check_eq("rd_done_pulses", 32'(rd_cnt - r0), 32'd1);
    end else begin
      check_eq("rd_unmatched_oe", 32'(oe_cyc - o0), 32'd0);
      check_eq("rd_unmatched_done", 32'(rd_cnt - r0), 32'd0);
    end
    check_eq("rd_post_oe", 32'(poe), 32'd0);
    check_eq("rd_busy_seen", 32'(busy_cyc - b0 > 0), 32'(pre >= 32));
    check_eq("rd_busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int          pre, doe;
    logic [4:0]  phy, ra;
    logic [15:0] d;
    logic [1:0]  ta;
    logic        t1, t2, t2o, hoe, poe;

    ref_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_oe", 32'(mdio_oe), 32'd0);
    check_eq("reset_o", 32'(mdio_o), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_wr_valid", 32'(wr_valid), 32'd0);
    check_eq("reset_rd_done", 32'(rd_done), 32'd0);
    check_eq("reset_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("reset_wr_data", 32'(wr_data), 32'd0);

    run_read(MY_PHY, 5'd2, 32);
    run_write(MY_PHY, 5'd4, 16'hA5C3, 2'b10, 32);
    run_read(MY_PHY, 5'd4, 32);
    run_write(5'd5, 5'd4, 16'h5A5A, 2'b10, 32);
    run_write(MY_PHY, 5'd4, 16'h0F0F, 2'b10, 31);
    run_read(MY_PHY, 5'd4, 32);
    run_write(MY_PHY, 5'd5, 16'hBEEF, 2'b11, 32);
    run_write(MY_PHY, 5'd3, 16'hFFFF, 2'b10, 32);
    run_read(MY_PHY, 5'd3, 32);
    run_read(MY_PHY, 5'd5, 32);
    run_write(MY_PHY, 5'd4, 16'h1234, 2'b10, 32);
    run_write(MY_PHY, 5'd0, 16'h8000, 2'b10, 32);
    run_read(MY_PHY, 5'd4, 32);
    run_read(MY_PHY, 5'd0, 32);

    for (int it = 0; it < 24; it++) begin
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : MY_PHY;
      ra  = 5'($urandom_range(0, 7));
      pre = ($urandom_range(0, 7) == 0) ? 31 : 32 + $urandom_range(0, 3);
      ta  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b10;
      d   = 16'($urandom);
      if (ra == 5'd0) d[15] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) run_write(phy, ra, d, ta, pre);
      else run_read(phy, ra, pre);
    end

    run_write(MY_PHY, 5'd4, 16'hC3A5, 2'b10, 32);
    do_read(MY_PHY, 5'd4, 32, 11, d, t1, t2, t2o, doe, hoe, poe);
    ref_reset();
    run_read(MY_PHY, 5'd2, 32);
    run_read(MY_PHY, 5'd4, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: PHY address this responder answers to.
REQ-002 SHALL have parameter PRE_LEN, default 32: minimum count of consecutive preamble ones.
REQ-003 SHALL have parameter ID1, default 16'h0022, and ID2, default 16'h1620: reset values of registers 2 and 3.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  system clock, at least 8x eth_mdc frequency.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 eth_mdc  input  1  management clock from the station, asynchronous to clk.
REQ-008 mdio_i  input  1  sampled eth_mdio line, asynchronous.
REQ-009 mdio_o  output  1  value this block drives onto eth_mdio.
REQ-010 mdio_oe  output  1  tristate enable for eth_mdio; 1 = drive mdio_o.
REQ-011 wr_valid  output  1  one-clk pulse when a register write commits.
REQ-012 wr_addr  output  5  register address of the committed write.
REQ-013 wr_data  output  16  data of the committed write.
REQ-014 rd_done  output  1  one-clk pulse when a read frame's last data bit is released.
REQ-015 busy  output  1  high from a valid ST through frame end.

Function
REQ-016 eth_mdc and mdio_i SHALL each pass a 2-flop synchronizer; an MDC rising edge ("edge") is detected when the synced MDC goes 0->1, and mdio is sampled in that same clk.
REQ-017 All bit processing SHALL occur only in edge cycles; mdio_o/mdio_oe SHALL update on the clk after the edge cycle.
REQ-018 SHALL implement states PRE, ST, OP, PHY, REG, TA, RDAT, WDAT.
REQ-019 PRE: each sampled 1 increments a counter saturating at PRE_LEN; a 0 with count==PRE_LEN SHALL go to ST; a 0 with count<PRE_LEN SHALL clear the count.
REQ-020 ST: sampled 1 -> OP and busy=1; sampled 0 -> PRE with count 0.
REQ-021 OP: two bits MSB first; 2'b10 = read, 2'b01 = write; 2'b00/2'b11 -> PRE with count 0 and busy=0.
REQ-022 PHY then REG: 5 bits each, MSB first; match = (PHYAD==PHY_ADDR); a mismatch SHALL still traverse the frame but SHALL never drive or write.
REQ-023 Read, matched: on the edge sampling REGAD[0], SHALL latch regfile[REGAD] into a 16-bit shifter, keep mdio_oe=0 (TA bit 1 is Z).
REQ-024 Read: on the next edge, mdio_oe=1, mdio_o=0 (TA bit 2); on each of the next 16 edges SHALL present data[15] down to data[0]; on the edge after data[0] is presented, mdio_oe=0, rd_done pulses, state -> PRE, count 0.
REQ-025 Write: TA bits sampled SHALL equal 1 then 0, else -> PRE, count 0, no write; then 16 data bits sampled MSB first in WDAT.
REQ-026 Write, matched: on the edge sampling data bit 0, SHALL update regfile[REGAD] and pulse wr_valid with wr_addr/wr_data, then -> PRE, count 0.
REQ-027 Registers 2 and 3 SHALL be read-only: writes are discarded with no wr_valid pulse.
REQ-028 Writing register 0 with bit 15 = 1 SHALL pulse wr_valid, then restore all registers to their reset values one clk later; register 0 bit 15 SHALL read back 0.
REQ-029 Unmatched read or write SHALL keep mdio_oe=0 and assert no pulses, but busy SHALL follow the frame.
REQ-030 mdio_oe SHALL never be 1 outside the TA-bit-2 and RDAT phases of a matched read.

Reset
REQ-031 On rst_n=0 at a clk edge: state=PRE, count=0, mdio_oe=0, mdio_o=1, wr_valid=0, rd_done=0, busy=0, wr_addr=0, wr_data=0.
REQ-032 Reset SHALL set MDC sync flops to 1 and MDIO sync flops to 1, so no spurious edge follows reset release.
REQ-033 Reset SHALL set regfile entries to 0, except reg2=ID1 and reg3=ID2.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no write and release the line on the same clk edge.

Verification
REQ-035 Read ID: 32 ones, ST=01, OP=10, PHYAD=1, REGAD=2 -> TA shows Z then 0, data 16'h0022 MSB first, rd_done pulses once, mdio_oe falls after bit 0.
REQ-036 Write/read: write 16'hA5C3 to reg 4 -> wr_valid, wr_addr=4, wr_data=16'hA5C3; a following read of reg 4 returns 16'hA5C3.
REQ-037 Mismatch and short preamble: PHYAD=5 write -> no wr_valid, mdio_oe stays 0; 31 ones then ST -> frame ignored, busy stays 0.
REQ-038 Bad turnaround and read-only: write with TA=11 -> no write; write 16'hFFFF to reg 3 -> no pulse, reg 3 still reads 16'h1620.
REQ-039 Soft reset: write reg 0 = 16'h8000 after reg 4 = 16'h1234 -> reg 4 reads 0, reg 0 reads 0.
REQ-040 Reset mid-read at data bit 7 -> mdio_oe=0 the next clk; a full preamble frame afterwards is served normally.
